// File: rtl/reg_read_stage_pkg.sv
// Shared widths and payload types for the register-read stage.
package reg_read_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PRF_ENTRIES = 64;
  localparam int unsigned PREG_BITS   = $clog2(PRF_ENTRIES);
  localparam int unsigned OP_BITS     = 6;

  typedef logic [PREG_BITS-1:0] preg_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [OP_BITS-1:0]   op_t;

  typedef struct packed {
    op_t   op;
    preg_t rs1;
    preg_t rs2;
    preg_t rd;
    xlen_t imm;
    logic  use_imm;
  } rr_uop_t;

  typedef struct packed {
    op_t   op;
    xlen_t src1;
    xlen_t src2;
    preg_t rd;
  } ex_packet_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// Scheduler / PRF / writeback / execute signals seen by the register-read stage.
interface reg_read_stage_if;
  import reg_read_stage_pkg::*;

  logic  flush;
  logic  iss_valid;
  logic  iss_ready;
  op_t   iss_op;
  preg_t iss_rs1_preg;
  preg_t iss_rs2_preg;
  preg_t iss_rd_preg;
  xlen_t iss_imm;
  logic  iss_use_imm;
  preg_t prf_rs1_addr;
  preg_t prf_rs2_addr;
  xlen_t prf_rs1_data;
  xlen_t prf_rs2_data;
  logic  wb_valid;
  preg_t wb_preg;
  xlen_t wb_data;
  logic  ex_valid;
  logic  ex_ready;
  op_t   ex_op;
  xlen_t ex_src1;
  xlen_t ex_src2;
  preg_t ex_rd_preg;

  // Environment side: scheduler, PRF, writeback bus and execute.
  modport master (
    output flush, iss_valid, iss_op, iss_rs1_preg, iss_rs2_preg, iss_rd_preg,
           iss_imm, iss_use_imm, prf_rs1_data, prf_rs2_data,
           wb_valid, wb_preg, wb_data, ex_ready,
    input  iss_ready, prf_rs1_addr, prf_rs2_addr,
           ex_valid, ex_op, ex_src1, ex_src2, ex_rd_preg
  );

  modport slave (
    input  flush, iss_valid, iss_op, iss_rs1_preg, iss_rs2_preg, iss_rd_preg,
           iss_imm, iss_use_imm, prf_rs1_data, prf_rs2_data,
           wb_valid, wb_preg, wb_data, ex_ready,
    output iss_ready, prf_rs1_addr, prf_rs2_addr,
           ex_valid, ex_op, ex_src1, ex_src2, ex_rd_preg
  );
endinterface

// File: rtl/reg_read_stage_rr_operand_sel.sv
// Per-source operand select: preg-0 zeroing, optional writeback forward, imm mux.
// Forwarding is compiled in only when RR_BYPASS_EN is defined.
module reg_read_stage_rr_operand_sel
  import reg_read_stage_pkg::*;
(
  input  preg_t preg_i,
  input  xlen_t prf_data_i,
  input  logic  wb_valid_i,
  input  preg_t wb_preg_i,
  input  xlen_t wb_data_i,
  input  logic  use_imm_i,
  input  xlen_t imm_i,
  output xlen_t src_c_o
);

`ifdef RR_BYPASS_EN
  logic wb_hit;
  assign wb_hit = wb_valid_i && (wb_preg_i == preg_i);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_preg_i, wb_data_i};
`endif

  always_comb begin
    src_c_o = '0;
    if (use_imm_i) begin
      src_c_o = imm_i;
    end else if (preg_i != '0) begin
`ifdef RR_BYPASS_EN
      src_c_o = wb_hit ? wb_data_i : prf_data_i;
`else
      src_c_o = prf_data_i;
`endif
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Two-stage elastic register-read stage: RR0 latches the uop and reads the PRF,
// RR1 holds the finished operand packet for execute. Optional macro: RR_BYPASS_EN.
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input logic             clk,
  input logic             rst,
  reg_read_stage_if.slave rr_if
);

  logic       rr0_valid_q, rr0_valid_d;
  rr_uop_t    rr0_uop_q,   rr0_uop_d;
  logic       rr1_valid_q, rr1_valid_d;
  ex_packet_t rr1_pkt_q,   rr1_pkt_d;
  logic       adv0, adv1;
  xlen_t      src1, src2;
  rr_uop_t    iss_uop;

  assign adv1 = !rr1_valid_q || rr_if.ex_ready;
  assign adv0 = !rr0_valid_q || adv1;

  assign iss_uop = '{op: rr_if.iss_op, rs1: rr_if.iss_rs1_preg, rs2: rr_if.iss_rs2_preg,
                     rd: rr_if.iss_rd_preg, imm: rr_if.iss_imm, use_imm: rr_if.iss_use_imm};

  reg_read_stage_rr_operand_sel u_sel_src1 (
    .preg_i     (rr0_uop_q.rs1),
    .prf_data_i (rr_if.prf_rs1_data),
    .wb_valid_i (rr_if.wb_valid),
    .wb_preg_i  (rr_if.wb_preg),
    .wb_data_i  (rr_if.wb_data),
    .use_imm_i  (1'b0),
    .imm_i      (rr0_uop_q.imm),
    .src_c_o    (src1)
  );

  reg_read_stage_rr_operand_sel u_sel_src2 (
    .preg_i     (rr0_uop_q.rs2),
    .prf_data_i (rr_if.prf_rs2_data),
    .wb_valid_i (rr_if.wb_valid),
    .wb_preg_i  (rr_if.wb_preg),
    .wb_data_i  (rr_if.wb_data),
    .use_imm_i  (rr0_uop_q.use_imm),
    .imm_i      (rr0_uop_q.imm),
    .src_c_o    (src2)
  );

  // RR0 fields are zeroed whenever it empties so the PRF addresses read 0 then.
  always_comb begin
    rr0_valid_d = rr0_valid_q;
    rr0_uop_d   = rr0_uop_q;
    rr1_valid_d = rr1_valid_q;
    rr1_pkt_d   = rr1_pkt_q;
    if (rr_if.flush) begin
      rr0_valid_d = 1'b0;
      rr0_uop_d   = '0;
      rr1_valid_d = 1'b0;
    end else begin
      if (adv0) begin
        rr0_valid_d = rr_if.iss_valid;
        rr0_uop_d   = rr_if.iss_valid ? iss_uop : '0;
      end
      if (adv1) begin
        rr1_valid_d = rr0_valid_q;
        if (rr0_valid_q) begin
          rr1_pkt_d.op   = rr0_uop_q.op;
          rr1_pkt_d.src1 = src1;
          rr1_pkt_d.src2 = src2;
          rr1_pkt_d.rd   = rr0_uop_q.rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr0_valid_q <= 1'b0;
      rr0_uop_q   <= '0;
      rr1_valid_q <= 1'b0;
      rr1_pkt_q   <= '0;
    end else begin
      rr0_valid_q <= rr0_valid_d;
      rr0_uop_q   <= rr0_uop_d;
      rr1_valid_q <= rr1_valid_d;
      rr1_pkt_q   <= rr1_pkt_d;
    end
  end

  assign rr_if.iss_ready    = adv0 && !rr_if.flush;
  assign rr_if.prf_rs1_addr = rr0_uop_q.rs1;
  assign rr_if.prf_rs2_addr = rr0_uop_q.rs2;
  assign rr_if.ex_valid     = rr1_valid_q;
  assign rr_if.ex_op        = rr1_pkt_q.op;
  assign rr_if.ex_src1      = rr1_pkt_q.src1;
  assign rr_if.ex_src2      = rr1_pkt_q.src2;
  assign rr_if.ex_rd_preg   = rr1_pkt_q.rd;

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Register-read stage directly downstream of the scheduler.
- Accepts one selected uop per cycle from the scheduler and reads both source operands from the physical register file (PRF).
- Applies writeback bypass and the immediate mux, then presents a fully-formed operand packet to the execute stage.
- Two-stage elastic pipeline (RR0: address latch / PRF read; RR1: operand latch) with valid/ready backpressure and flush.

Parameters:
XLEN, 32, operand/data width
PRF_ENTRIES, 64, physical registers; PREG_BITS = $clog2(PRF_ENTRIES)
OP_BITS, 6, FU opcode width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
flush  in  1  squash all in-flight uops
iss_valid  in  1  scheduler presents a uop
iss_ready  out  1  stage can accept
iss_op  in  OP_BITS  FU opcode
iss_rs1_preg  in  PREG_BITS  source 1 physical reg
iss_rs2_preg  in  PREG_BITS  source 2 physical reg
iss_rd_preg  in  PREG_BITS  destination physical reg
iss_imm  in  XLEN  immediate
iss_use_imm  in  1  src2 := imm
prf_rs1_addr  out  PREG_BITS  PRF read port 1 address
prf_rs2_addr  out  PREG_BITS  PRF read port 2 address
prf_rs1_data  in  XLEN  combinational read data, port 1
prf_rs2_data  in  XLEN  combinational read data, port 2
wb_valid  in  1  writeback this cycle
wb_preg  in  PREG_BITS  writeback destination
wb_data  in  XLEN  writeback value
ex_valid  out  1  operand packet valid
ex_ready  in  1  execute accepts
ex_op  out  OP_BITS  opcode
ex_src1  out  XLEN  operand 1
ex_src2  out  XLEN  operand 2 (imm if use_imm)
ex_rd_preg  out  PREG_BITS  destination

Behaviour:
- Reset (synchronous, rst=1 at posedge): rr0_valid=0, rr1_valid=0; ex_valid=0, ex_* data=0, iss_ready=1 in the cycle after reset. prf_rsN_addr=0 while rr0 is empty.
- Handshake: a transfer occurs when valid && ready on the same posedge. Producers do not drop valid until accepted; ex_* stay stable while ex_valid && !ex_ready.
- adv1 = !rr1_valid || ex_ready. adv0 = !rr0_valid || adv1. iss_ready = adv0 (combinational, no bubble at full throughput).
- RR0: on issue accept, latch op/rs1/rs2/rd/imm/use_imm. prf_rsN_addr are driven from the RR0 registers.
- RR0 read: each cycle, RR0 computes src from PRF data. Preg 0 reads as 0. If bypass applies, wb_data is used instead (see Optional Feature).
- While RR0 is stalled it re-reads every cycle, so values written back during the stall are picked up automatically.
- RR1: on adv1 && rr0_valid, latch computed src1, src2 (or imm), op, rd. rr1_valid <= rr0_valid when adv1.
- Latency: issue accept at edge N gives ex_valid high after edge N+1. Throughput is 1/cycle.
- Full: both stages valid and ex_ready=0 gives iss_ready=0.
- Simultaneous ex accept + issue accept in the full state is allowed; all stages shift.
- Flush: at the posedge, rr0_valid and rr1_valid are cleared. Flush has priority over issue accept and RR0→RR1 transfer. iss_ready is forced 0 while flush=1.
- Reset mid-operation behaves identically to flush, plus data registers are cleared.
- Width: no arithmetic. Immediate is already XLEN sign-extended by decode.

Optional Feature:
- RR_BYPASS_EN defined:
  - In RR0, if wb_valid && wb_preg==rrN_preg && rrN_preg!=0, srcN = wb_data (same-cycle forward over stale PRF data).
  - The scheduler may wake dependents on the writeback cycle.
- Undefined:
  - No compare logic; srcN always comes from PRF.
  - The scheduler must delay wakeup by one cycle.
  - The stage itself is otherwise identical.

Decomposition:
- CORE_PKG gains XLEN, PRF_ENTRIES, PREG_BITS, OP_BITS, and an rr_uop_t struct {op, rs1, rs2, rd, imm, use_imm} plus an ex_packet_t struct {op, src1, src2, rd}.
- One natural sub-module: rr_operand_sel. It is combinational per source and handles preg-0 zeroing, the bypass compare, and the imm mux. It is instantiated twice.
- A later revision may carry these signals in scheduler_reg_read_if.

Test Plan:
- Single issue: rs1=5 (PRF=0x11), rs2=6 (PRF=0x22), rd=9, ex_ready=1 → ex_valid 2 edges later with src1=0x11, src2=0x22, rd=9; iss_ready stays 1.
- Back-to-back 4 uops, ex_ready=1 → 4 consecutive ex_valid cycles in order, no bubbles.
- Backpressure: ex_ready=0 for 3 cycles with a stream → iss_ready drops after 2 accepts; packet held stable; drains in order when ex_ready=1.
- Bypass (RR_BYPASS_EN): rs1=7, PRF[7]=0xDEAD, wb_valid=1 wb_preg=7 wb_data=0xBEEF in the RR0 cycle → src1=0xBEEF. Without the macro → 0xDEAD.
- Zero reg / imm: rs1=0, use_imm=1, imm=0xFFFFFFF0 → src1=0, src2=0xFFFFFFF0. wb to preg 0 is not forwarded.
- Flush with both stages full → ex_valid=0 next cycle, iss_ready=0 during flush, and the squashed uops never appear at ex.
